// File: rtl/rebuster_arbiter_if.sv
// Bus-side signal bundle for the Buster Level II arbiter.
// master = arbiter side, slave = pins/board side.
interface rebuster_arbiter_if #(
    parameter int unsigned NUM_SLOTS = 5
);
    logic                 sbr_n_in;
    logic [NUM_SLOTS-1:0] ebr_n_in;
    logic                 ebgack_n_in;
    logic                 bg_n_in;
    logic                 bgack_n_in;
    logic                 as_n_in;
    logic                 fcs_n_in;

    logic                 br_n_out;
    logic                 br_n_oe;
    logic                 bgack_n_out;
    logic                 bgack_n_oe;
    logic                 sbg_n_out;
    logic                 sbg_n_oe;
    logic [NUM_SLOTS-1:0] ebg_n_out;
    logic [NUM_SLOTS-1:0] ebg_n_oe;
    logic                 cpu_owns;
    logic [2:0]           owner_id;
    logic                 timeout_pulse;

    modport master (
        input  sbr_n_in, ebr_n_in, ebgack_n_in, bg_n_in, bgack_n_in, as_n_in, fcs_n_in,
        output br_n_out, br_n_oe, bgack_n_out, bgack_n_oe, sbg_n_out, sbg_n_oe,
               ebg_n_out, ebg_n_oe, cpu_owns, owner_id, timeout_pulse
    );

    modport slave (
        output sbr_n_in, ebr_n_in, ebgack_n_in, bg_n_in, bgack_n_in, as_n_in, fcs_n_in,
        input  br_n_out, br_n_oe, bgack_n_out, bgack_n_oe, sbg_n_out, sbg_n_oe,
               ebg_n_out, ebg_n_oe, cpu_owns, owner_id, timeout_pulse
    );
endinterface

// File: rtl/rebuster_arbiter.sv
// Buster Level II bus arbiter: takes the bus from the 68030 and hands it to the
// SDMAC or one Zorro slot at a time, stepping only on CPUCLK rising strobes.
module rebuster_arbiter #(
    parameter int unsigned NUM_SLOTS     = 5,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned GRANT_TIMEOUT = 15
) (
    input  logic               clk100,
    input  logic               reset,
    input  logic               cpuclk_rising,
    rebuster_arbiter_if.master bus
);
    localparam int unsigned SW    = NUM_SLOTS + 6;
    localparam int unsigned PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int unsigned CNT_W = 8;
    localparam logic [2:0]  OWNER_SDMAC = 3'd5;
    localparam logic [2:0]  OWNER_NONE  = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE, ST_REQ, ST_ACQ, ST_GRANT, ST_MASTER, ST_RELEASE
    } state_e;

    logic [SYNC_STAGES-1:0][SW-1:0] sync_q;
    logic [SW-1:0]        raw, s;
    logic                 s_sbr_n, s_ebgack_n, s_bg_n, s_bgack_n, s_as_n, s_fcs_n;
    logic [NUM_SLOTS-1:0] s_ebr_n;
    logic                 req_any, active, owner_req, rr_found, rel;
    logic [PTR_W-1:0]     rr_idx;

    state_e               state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [2:0]           owner_q, owner_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 br_n_q, br_n_d, br_oe_q, br_oe_d;
    logic                 bgack_n_q, bgack_n_d, bgack_oe_q, bgack_oe_d;
    logic                 sbg_n_q, sbg_n_d;
    logic [NUM_SLOTS-1:0] ebg_n_q, ebg_n_d;
    logic                 cpu_owns_q, cpu_owns_d;
    logic                 timeout_q, timeout_d;
    logic                 grant_oe_q;

    assign raw = {bus.sbr_n_in, bus.ebr_n_in, bus.ebgack_n_in, bus.bg_n_in,
                  bus.bgack_n_in, bus.as_n_in, bus.fcs_n_in};

    // Every asynchronous pin goes through the same preset-high chain
    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q[0] <= raw;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s          = sync_q[SYNC_STAGES-1];
    assign s_fcs_n    = s[0];
    assign s_as_n     = s[1];
    assign s_bgack_n  = s[2];
    assign s_bg_n     = s[3];
    assign s_ebgack_n = s[4];
    assign s_ebr_n    = s[5 +: NUM_SLOTS];
    assign s_sbr_n    = s[SW-1];

    assign req_any = !s_sbr_n || !(&s_ebr_n);
    assign active  = !s_as_n || !s_fcs_n || !s_ebgack_n;

    // Request line of whoever currently holds the grant
    always_comb begin
        owner_req = 1'b0;
        if (owner_q == OWNER_SDMAC) begin
            owner_req = !s_sbr_n;
        end else begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++)
                if (owner_q == 3'(i)) owner_req = !s_ebr_n[PTR_W'(i)];
        end
    end

    // Round-robin search starting at the pointer, wrapping at the last slot
    always_comb begin
        int unsigned j;
        j        = 0;
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            j = (32'(ptr_q) + i) % NUM_SLOTS;
            if (!rr_found && !s_ebr_n[PTR_W'(j)]) begin
                rr_found = 1'b1;
                rr_idx   = PTR_W'(j);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        br_n_d     = br_n_q;
        br_oe_d    = br_oe_q;
        bgack_n_d  = bgack_n_q;
        bgack_oe_d = bgack_oe_q;
        sbg_n_d    = sbg_n_q;
        ebg_n_d    = ebg_n_q;
        cpu_owns_d = cpu_owns_q;
        timeout_d  = 1'b0;
        rel        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    state_d = ST_REQ;
                    br_n_d  = 1'b0;
                    br_oe_d = 1'b1;
                end
            end
            ST_REQ: begin
                if (!req_any) begin
                    state_d = ST_IDLE;
                    br_n_d  = 1'b1;
                    br_oe_d = 1'b0;
                end else if (!s_bg_n && s_as_n && s_bgack_n) begin
                    state_d    = ST_ACQ;
                    bgack_n_d  = 1'b0;
                    bgack_oe_d = 1'b1;
                    br_n_d     = 1'b1;
                    br_oe_d    = 1'b0;
                    cpu_owns_d = 1'b0;
                end
            end
            ST_ACQ: begin
                if (!s_sbr_n) begin
                    state_d = ST_GRANT;
                    sbg_n_d = 1'b0;
                    owner_d = OWNER_SDMAC;
                    cnt_d   = '0;
                end else if (rr_found) begin
                    state_d         = ST_GRANT;
                    ebg_n_d         = '1;
                    ebg_n_d[rr_idx] = 1'b0;
                    owner_d         = 3'(rr_idx);
                    cnt_d           = '0;
                end else begin
                    state_d = ST_RELEASE;
                end
            end
            ST_GRANT: begin
                if (active) begin
                    state_d = ST_MASTER;
                end else if (!owner_req) begin
                    rel = 1'b1;
                end else begin
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(GRANT_TIMEOUT)) begin
                        rel       = 1'b1;
                        timeout_d = 1'b1;
                    end
                end
            end
            ST_MASTER: begin
                if (!owner_req && !active) rel = 1'b1;
            end
            ST_RELEASE: begin
                if (req_any) begin
                    state_d = ST_ACQ;
                end else begin
                    state_d    = ST_IDLE;
                    bgack_n_d  = 1'b1;
                    bgack_oe_d = 1'b0;
                    cpu_owns_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Dropping a grant always passes through RELEASE before the next owner
        if (rel) begin
            state_d = ST_RELEASE;
            sbg_n_d = 1'b1;
            ebg_n_d = '1;
            owner_d = OWNER_NONE;
            if (owner_q != OWNER_SDMAC) ptr_d = PTR_W'((32'(owner_q) + 32'd1) % NUM_SLOTS);
        end
    end

    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            owner_q    <= OWNER_NONE;
            cnt_q      <= '0;
            br_n_q     <= 1'b1;
            br_oe_q    <= 1'b0;
            bgack_n_q  <= 1'b1;
            bgack_oe_q <= 1'b0;
            sbg_n_q    <= 1'b1;
            ebg_n_q    <= '1;
            cpu_owns_q <= 1'b1;
            timeout_q  <= 1'b0;
            grant_oe_q <= 1'b0;
        end else begin
            grant_oe_q <= 1'b1;
            timeout_q  <= cpuclk_rising && timeout_d;
            if (cpuclk_rising) begin
                state_q    <= state_d;
                ptr_q      <= ptr_d;
                owner_q    <= owner_d;
                cnt_q      <= cnt_d;
                br_n_q     <= br_n_d;
                br_oe_q    <= br_oe_d;
                bgack_n_q  <= bgack_n_d;
                bgack_oe_q <= bgack_oe_d;
                sbg_n_q    <= sbg_n_d;
                ebg_n_q    <= ebg_n_d;
                cpu_owns_q <= cpu_owns_d;
            end
        end
    end

    assign bus.br_n_out      = br_n_q;
    assign bus.br_n_oe       = br_oe_q;
    assign bus.bgack_n_out   = bgack_n_q;
    assign bus.bgack_n_oe    = bgack_oe_q;
    assign bus.sbg_n_out     = sbg_n_q;
    assign bus.sbg_n_oe      = grant_oe_q;
    assign bus.ebg_n_out     = ebg_n_q;
    assign bus.ebg_n_oe      = {NUM_SLOTS{grant_oe_q}};
    assign bus.cpu_owns      = cpu_owns_q;
    assign bus.owner_id      = owner_q;
    assign bus.timeout_pulse = timeout_q;
endmodule

// File: tb/tb_rebuster_arbiter.sv
// Bench for rebuster_arbiter: directed ownership/timeout/reset sequences, then
// random request traffic, all checked against a behavioural bus-ownership model.
module tb_rebuster_arbiter;
    localparam int unsigned NS  = 5;
    localparam int          TMO = 15;

    logic clk100 = 1'b0;
    logic reset;
    logic cpuclk_rising;

    rebuster_arbiter_if #(.NUM_SLOTS(NS)) bus ();

    rebuster_arbiter #(.NUM_SLOTS(NS), .SYNC_STAGES(2), .GRANT_TIMEOUT(TMO)) dut (
        .clk100        (clk100),
        .reset         (reset),
        .cpuclk_rising (cpuclk_rising),
        .bus           (bus)
    );

    always #5 clk100 = ~clk100;

    int n_checks   = 0;
    int n_fail     = 0;
    int n_tmo_seen = 0;

    // Model: who has the bus and what the arbiter is doing with it
    bit m_br, m_have_bus, m_pick, m_drop, m_used, m_tmo;
    int m_owner, m_ptr, m_idle;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_br = 0; m_have_bus = 0; m_pick = 0; m_drop = 0; m_used = 0; m_tmo = 0;
        m_owner = -1; m_ptr = 0; m_idle = 0;
    endtask

    function automatic bit slot_req(input int k);
        return ((32'(bus.ebr_n_in) >> k) & 32'd1) == 32'd0;
    endfunction

    // One CPUCLK edge of the reference behaviour, using the inputs held over the last period
    task automatic model_step();
        bit req_any, active, oreq, rel;
        int win;
        req_any = !bus.sbr_n_in || (bus.ebr_n_in != '1);
        active  = !bus.as_n_in || !bus.fcs_n_in || !bus.ebgack_n_in;
        m_tmo = 0; rel = 0; oreq = 0; win = -1;
        if (m_owner == 5) oreq = !bus.sbr_n_in;
        else if (m_owner >= 0) oreq = slot_req(m_owner);
        if (!m_have_bus) begin
            if (!m_br) m_br = req_any;
            else if (!req_any) m_br = 0;
            else if (!bus.bg_n_in && bus.as_n_in && bus.bgack_n_in) begin
                m_br = 0; m_have_bus = 1; m_pick = 1;
            end
        end else if (m_pick) begin
            m_pick = 0;
            if (!bus.sbr_n_in) win = 5;
            else for (int k = 0; k < NS; k++) begin
                int cand;
                cand = (m_ptr + k) % NS;
                if (win < 0 && slot_req(cand)) win = cand;
            end
            if (win >= 0) begin m_owner = win; m_used = 0; m_idle = 0; end
            else m_drop = 1;
        end else if (m_drop) begin
            m_drop = 0;
            if (req_any) m_pick = 1;
            else m_have_bus = 0;
        end else begin
            if (!m_used) begin
                if (active) m_used = 1;
                else if (!oreq) rel = 1;
                else begin
                    m_idle++;
                    if (m_idle == TMO) begin rel = 1; m_tmo = 1; end
                end
            end else if (!oreq && !active) rel = 1;
            if (rel) begin
                if (m_owner < NS) m_ptr = (m_owner + 1) % NS;
                m_owner = -1; m_drop = 1;
            end
        end
    endtask

    task automatic compare_outputs();
        logic [NS-1:0] e_ebg;
        e_ebg = '1;
        if (m_owner >= 0 && m_owner < NS) e_ebg = e_ebg ^ (NS'(1) << m_owner);
        check("br_n",     32'(bus.br_n_out),      32'(!m_br));
        check("br_oe",    32'(bus.br_n_oe),       32'(m_br));
        check("bgack_n",  32'(bus.bgack_n_out),   32'(!m_have_bus));
        check("bgack_oe", 32'(bus.bgack_n_oe),    32'(m_have_bus));
        check("sbg_n",    32'(bus.sbg_n_out),     32'(m_owner != 5));
        check("ebg_n",    32'(bus.ebg_n_out),     32'(e_ebg));
        check("grant_oe", 32'({bus.sbg_n_oe, bus.ebg_n_oe}), 32'h3F);
        check("cpu_owns", 32'(bus.cpu_owns),      32'(!m_have_bus));
        check("owner_id", 32'(bus.owner_id),      (m_owner < 0) ? 32'd7 : 32'(m_owner));
        check("timeout",  32'(bus.timeout_pulse), 32'(m_tmo));
        if (bus.timeout_pulse === 1'b1) n_tmo_seen++;
    endtask

    // One CPUCLK period = 4 clk100 cycles; strobe on the last one, then check
    task automatic tick();
        @(posedge clk100); #1;
        check("tmo_width", 32'(bus.timeout_pulse), 32'd0);
        repeat (2) @(posedge clk100);
        @(negedge clk100) cpuclk_rising = 1'b1;
        @(posedge clk100); #1;
        cpuclk_rising = 1'b0;
        model_step();
        compare_outputs();
    endtask

    task automatic set_quiet();
        bus.sbr_n_in = 1'b1; bus.ebr_n_in = '1; bus.ebgack_n_in = 1'b1;
        bus.bg_n_in = 1'b1; bus.bgack_n_in = 1'b1; bus.as_n_in = 1'b1; bus.fcs_n_in = 1'b1;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_br"},    32'({bus.br_n_out, bus.br_n_oe}), 32'h2);
        check({tag, "_bgack"}, 32'({bus.bgack_n_out, bus.bgack_n_oe}), 32'h2);
        check({tag, "_sbg"},   32'({bus.sbg_n_out, bus.sbg_n_oe}), 32'h2);
        check({tag, "_ebg"},   32'({bus.ebg_n_out, bus.ebg_n_oe}), 32'h3E0);
        check({tag, "_cpu"},   32'(bus.cpu_owns), 32'd1);
        check({tag, "_owner"}, 32'(bus.owner_id), 32'd7);
        check({tag, "_tmo"},   32'(bus.timeout_pulse), 32'd0);
    endtask

    task automatic random_inputs();
        if ($urandom_range(5) == 0) bus.sbr_n_in = ~bus.sbr_n_in;
        for (int k = 0; k < NS; k++)
            if ($urandom_range(5) == 0) bus.ebr_n_in = bus.ebr_n_in ^ (NS'(1) << k);
        bus.as_n_in     = ($urandom_range(7) != 0);
        bus.fcs_n_in    = ($urandom_range(7) != 0);
        bus.ebgack_n_in = ($urandom_range(9) != 0);
        bus.bg_n_in     = ($urandom_range(1) != 0);
        bus.bgack_n_in  = ($urandom_range(9) != 0);
    endtask

    initial begin
        reset = 1'b1;
        cpuclk_rising = 1'b0;
        set_quiet();
        model_reset();
        #23;
        reset_checks("rst0");
        @(negedge clk100) reset = 1'b0;

        // Slot 2 gets the bus, FCS_n keeps it past the request drop
        bus.ebr_n_in[2] = 1'b0; bus.bg_n_in = 1'b0;
        repeat (3) tick();
        check("own_slot2", 32'(bus.owner_id), 32'd2);
        check("ebg_slot2", 32'(bus.ebg_n_out), 32'h1B);
        bus.fcs_n_in = 1'b0; tick();
        bus.ebr_n_in[2] = 1'b1; tick();
        check("hold_fcs", 32'(bus.ebg_n_out), 32'h1B);
        bus.fcs_n_in = 1'b1; tick();
        check("rel_grant", 32'(bus.ebg_n_out), 32'h1F);
        check("rel_bgack", 32'(bus.bgack_n_out), 32'd0);
        tick();
        check("idle_bgack", 32'(bus.bgack_n_out), 32'd1);
        check("idle_cpu", 32'(bus.cpu_owns), 32'd1);

        // Pointer at 3: slot 4 before slot 1, then wrap to slot 1
        bus.ebr_n_in[4] = 1'b0; bus.ebr_n_in[1] = 1'b0;
        repeat (3) tick();
        check("rr_slot4", 32'(bus.owner_id), 32'd4);
        bus.ebr_n_in[4] = 1'b1;
        repeat (3) tick();
        check("rr_wrap1", 32'(bus.owner_id), 32'd1);
        check("rr_bgack", 32'(bus.bgack_n_out), 32'd0);

        // Asynchronous reset in the middle of a MASTER tenure
        bus.fcs_n_in = 1'b0; tick();
        @(posedge clk100); #3 reset = 1'b1;
        #1 reset_checks("rst_master");
        set_quiet();
        model_reset();
        @(negedge clk100) reset = 1'b0;

        // Idle grant to slot 0 is revoked once, exactly on the 15th GRANT edge
        bus.ebr_n_in[0] = 1'b0; bus.bg_n_in = 1'b0;
        n_tmo_seen = 0;
        repeat (20) tick();
        check("tmo_count", 32'(n_tmo_seen), 32'd1);

        set_quiet();
        for (int n = 0; n < 1500; n++) begin
            random_inputs();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rebuster_arbiter.md
Name: rebuster_arbiter

Overview:
- Bus arbiter for Buster Level II.
- Resolves bus requests from the SDMAC (SBR_n) and the five Zorro slots (EBR_n[4:0]).
- Obtains the bus from the 68030 via BR_n/BG_n/BGACK_n, then issues one grant at a time on SBG_n/EBG_n.
- Instantiated inside rebuster_core. Runs on clk100 and advances only on the cpuclk_rising strobe, so all bus-visible transitions align to CPUCLK.

Parameters:
- NUM_SLOTS, 5, number of Zorro request/grant pairs.
- SYNC_STAGES, 2, flip-flop synchroniser depth for every asynchronous input (minimum 2).
- GRANT_TIMEOUT, 15, CPUCLK cycles a granted master may stay idle before the grant is revoked (1..255).

Ports:
- clk100  input  1  100 MHz core clock, phase-locked to CPUCLK.
- reset  input  1  asynchronous, active-high reset.
- cpuclk_rising  input  1  one-clk100-cycle strobe marking a CPUCLK rising edge.
- sbr_n_in  input  1  SDMAC bus request.
- ebr_n_in  input  NUM_SLOTS  Zorro bus requests.
- ebgack_n_in  input  1  Z2 bus grant acknowledge.
- bg_n_in  input  1  CPU bus grant.
- bgack_n_in  input  1  BGACK_n pin readback.
- as_n_in  input  1  AS_n pin readback.
- fcs_n_in  input  1  FCS_n pin readback.
- br_n_out, br_n_oe  output  1,1  bus request to CPU.
- bgack_n_out, bgack_n_oe  output  1,1  bus grant acknowledge to CPU.
- sbg_n_out, sbg_n_oe  output  1,1  SDMAC grant.
- ebg_n_out, ebg_n_oe  output  NUM_SLOTS each  Zorro grants.
- cpu_owns  output  1  high while the CPU is bus master.
- owner_id  output  3  current grantee: 0..4 = slot, 5 = SDMAC, 7 = none.
- timeout_pulse  output  1  one-clk100 pulse when a grant is revoked by timeout.

Behaviour:
- Reset (asynchronous, while reset = 1):
  - All *_out = 1 and all *_oe = 0.
  - cpu_owns = 1, owner_id = 7, timeout_pulse = 0.
  - Synchroniser chains preset to 1. Round-robin pointer = 0. State = IDLE.
- After reset: sbg_n_oe and ebg_n_oe = 1 permanently. br_n_oe and bgack_n_oe = 1 only while driving low, otherwise 0 (open-drain style).
- All inputs except cpuclk_rising pass through SYNC_STAGES flops on clk100. The state machine and outputs update only in clk100 cycles where cpuclk_rising = 1.
- Derived signals (synchronised inputs):
  - req_any = !sbr_n | any(!ebr_n).
  - active = !as_n | !fcs_n | !ebgack_n.
- States and transitions:
  - IDLE: br released. If req_any -> REQ, driving br_n_out = 0 with br_n_oe = 1 on that same edge.
  - REQ: br_n low.
    - If req_any drops -> IDLE, releasing br.
    - If !bg_n & as_n & bgack_n -> ACQ: drive bgack_n low, release br, cpu_owns = 0.
  - ACQ: pick the winner.
    - SDMAC has fixed highest priority.
    - Otherwise the first requesting slot searching from pointer upward, wrapping at NUM_SLOTS-1 -> 0.
    - Assert that grant low, set owner_id, clear timeout counter -> GRANT.
    - If no request remains -> RELEASE.
  - GRANT:
    - If active -> MASTER.
    - Else if the owner's request is deasserted -> RELEASE.
    - Else count up; when count reaches GRANT_TIMEOUT -> RELEASE and pulse timeout_pulse.
  - MASTER: when the owner's request is deasserted and !active -> RELEASE.
  - RELEASE:
    - Deassert the grant, owner_id = 7.
    - If the owner was a slot, pointer = owner+1 (wrapping).
    - If any request is pending, stay bus master -> ACQ (bgack stays low).
    - Otherwise release bgack, cpu_owns = 1 -> IDLE.
- Invariants:
  - At most one of sbg_n_out/ebg_n_out is low at any time.
  - A grant is never asserted while bgack_n_out is released.
  - Grant changes take at least one CPUCLK cycle, because RELEASE is always visited between owners.
- Simultaneous requests in ACQ: SDMAC wins. Among slots, the pointer decides. The counter is 8 bits and saturates.
- A reset asserted mid-operation returns everything to the reset values immediately, with no handshake completion.

Test Plan:
- Reset, then EBR_n[2] = 0, BG_n answers 2 CPUCLKs after BR_n falls -> BR_n low 1 edge after sync; BGACK_n low and BR_n released on the edge BG_n is seen; EBG_n[2] low on the next edge; owner_id = 2.
- Continuing: FCS_n low for 3 cycles, EBR_n[2] released while FCS_n is still low -> EBG_n[2] held until FCS_n high; then grant high; BGACK_n high one edge later; cpu_owns = 1; pointer = 3.
- SBR_n and EBR_n[0] low together -> SBG_n granted first; after SDMAC releases, EBG_n[0] granted without BGACK_n going high in between.
- EBR_n[4] and EBR_n[1] held low with pointer = 3 -> slot 4 granted; after release, slot 1 (wrap-around).
- Grant to slot 0 with no AS_n/FCS_n/EBGACK_n activity and request held -> revoked after exactly 15 CPUCLK edges in GRANT; timeout_pulse = 1 for one clk100 cycle.
- Reset asserted while in MASTER -> all outputs return to reset values asynchronously; owner_id = 7.
